// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply / restoring divide unit.
// One result bit per clock; done pulses once when Result1/Result2 update.
module mcycle_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             Start,
   input  logic             MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COMPUTE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      counter;
   logic               op;
   // multiplicand for multiply, divisor for divide
   logic [WIDTH-1:0]   opb;
   // multiply: {partial product high, multiplier shifting out}
   // divide:   {partial remainder, dividend shifting in quotient}
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH:0]     msum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   rsub;
   logic               ge;

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      msum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      shifted  = acc[2*WIDTH-1:WIDTH-1];
      ge       = (shifted >= {1'b0, opb});
      // when ge holds the true difference is below the divisor, so it fits
      rsub     = shifted[WIDTH-1:0] - opb;
      acc_next = {msum, acc[WIDTH-1:1]};
      if (op) begin
         if (ge) begin
            acc_next = {rsub, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
         end
      end
   end

   // Control FSM, operand latch, iteration state and result registers
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         counter <= '0;
         op      <= 1'b0;
         opb     <= '0;
         acc     <= '0;
         Result1 <= '0;
         Result2 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  op      <= MCycleOp;
                  counter <= '0;
                  state   <= COMPUTE;
                  if (MCycleOp) begin
                     acc <= {{WIDTH{1'b0}}, Operand1};
                     opb <= Operand2;
                  end else begin
                     acc <= {{WIDTH{1'b0}}, Operand2};
                     opb <= Operand1;
                  end
               end
            end
            COMPUTE: begin
               acc     <= acc_next;
               counter <= counter + CW'(1);
               if (counter == CW'(WIDTH-1)) begin
                  Result1 <= acc_next[WIDTH-1:0];
                  Result2 <= acc_next[2*WIDTH-1:WIDTH];
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign Busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Multi-cycle integer multiply/divide unit. Sits directly downstream of the control unit.
- Consumes the control unit's M_Start and MCycleOp. Returns done so the control unit stalls the pipeline until the result is ready.
- The datapath supplies the operands and writes back Result1/Result2.
- One operation runs at a time: iterative shift-add multiply, or restoring divide, one bit per clock.

Parameters:
WIDTH, 32, operand width in bits (both operands and each result half)

Ports:
CLK  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
Start  input  1  operation request (driven by control unit M_Start)
MCycleOp  input  1  0 = unsigned multiply, 1 = unsigned divide
Operand1  input  WIDTH  multiplicand / dividend
Operand2  input  WIDTH  multiplier / divisor
Result1  output  WIDTH  product low half / quotient
Result2  output  WIDTH  product high half / remainder
Busy  output  1  operation in progress (COMPUTE or DONE)
done  output  1  one-cycle pulse: Result1/Result2 valid

Behaviour:
- Reset (rst=0, asynchronous, any state including mid-operation):
  - state=IDLE; counter=0; internal shift registers=0.
  - Result1=0, Result2=0, Busy=0, done=0.
  - No stale done after release.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - Start=1 at a rising edge accepts the operation.
  - Operand1, Operand2 and MCycleOp are latched internally; counter=0; state->COMPUTE.
  - Start=0: remain IDLE, results held.
- COMPUTE:
  - One iteration per edge, counter increments.
  - Operand inputs and Start are ignored, so the requester may change them freely.
  - The edge performing iteration WIDTH (counter=WIDTH-1) writes final results to Result1/Result2 and moves state->DONE.
- DONE:
  - done=1, Busy=1 for exactly one cycle; next edge -> IDLE unconditionally.
  - Start high during DONE is ignored. The control unit must deassert Start after seeing done and re-raise it for a new operation.
- Latency: done is high in the cycle following the edge that is WIDTH edges after the accepting edge, i.e. WIDTH+1 edges from accept to done deassert.
- Throughput: next accept is possible at the edge after DONE, one per WIDTH+2 cycles.
- Busy = (state != IDLE). done = (state == DONE). Both are registered state decodes with no combinational path from Start.
- Multiply (MCycleOp=0):
  - Unsigned WIDTH x WIDTH -> 2*WIDTH product.
  - Shift-add using a 2*WIDTH accumulator, one multiplier bit per iteration (LSB first).
  - Result2 = product[2W-1:W], Result1 = product[W-1:0].
  - No overflow flag.
- Divide (MCycleOp=1):
  - Unsigned restoring division, one quotient bit per iteration (MSB first).
  - Partial remainder is W+1 bits for the trial subtract.
  - Result1 = quotient, Result2 = remainder.
- Divide by zero (Operand2=0): Result1 = all ones, Result2 = Operand1. Takes full latency; no special early exit.
- Result1/Result2 hold their value from DONE until the next completed operation; they are not updated during COMPUTE.
- Output changes other than at reset occur only on the edge entering DONE.

Test Plan:
- Reset then idle: rst=0 mid-COMPUTE of a multiply, release -> Busy=0, done=0, Result1=Result2=0. Start=0 for 40 cycles -> no done.
- Multiply: Op1=0xFFFFFFFF, Op2=0xFFFFFFFF, Start 1 cycle, MCycleOp=0 -> done exactly 32 edges after accept. Result2=0xFFFFFFFE, Result1=0x00000001. done high exactly 1 cycle.
- Divide: Op1=100, Op2=7, MCycleOp=1 -> Result1=14, Result2=2. Operands changed to 0 during COMPUTE -> results unaffected.
- Divide by zero: Op1=0x12345678, Op2=0 -> Result1=0xFFFFFFFF, Result2=0x12345678, same latency.
- Start held high continuously with Op1=3, Op2=5 multiply:
  - ignored during COMPUTE/DONE;
  - re-accepted at first IDLE edge;
  - consecutive done pulses spaced 34 cycles;
  - Result1=15, Result2=0 each time.
- Back-to-back mixed ops: multiply 0x10000*0x10000 then divide 0x80000000/3 -> Result2=1, Result1=0 after the first; then Result1=0x2AAAAAAA, Result2=2. Busy low exactly one cycle between operations.
